// File: rtl/ysyx_23060201_ifu_if.sv
// Bus bundle for the instruction fetch unit: EXU next-PC, instruction memory
// request/response, and the {pc, inst} hand-off to decode.
interface ysyx_23060201_ifu_if;
    logic        npc_valid;
    logic [31:0] npc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    modport master (
        input  npc_valid, npc,
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output out_valid, out_pc, out_inst, fetch_err, fetch_cnt,
        input  out_ready
    );

    modport slave (
        output npc_valid, npc,
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  out_valid, out_pc, out_inst, fetch_err, fetch_cnt,
        output out_ready
    );
endinterface

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time over a valid/ready
// memory port, result handed to decode, then waits for the EXU's next PC.
module ysyx_23060201_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_23060201_ifu_if.master bus
);

    // Last counter value that may still accept a response before timing out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        REQ,
        WAIT,
        OUT,
        NPC
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst, inst_nxt;
    logic        err, err_nxt;
    logic [7:0]  wcnt, wcnt_nxt;
    logic [31:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
            err   <= 1'b0;
            wcnt  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
            err   <= err_nxt;
            wcnt  <= wcnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        err_nxt   = err;
        wcnt_nxt  = wcnt;
        cnt_nxt   = cnt;
        case (state)
            IDLE: state_nxt = CHK;
            CHK: begin
                // A misaligned PC never reaches memory; report it directly.
                if (pc[1:0] != 2'b00) begin
                    inst_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = OUT;
                end else begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.imem_req_ready) begin
                    wcnt_nxt  = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    inst_nxt  = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
                    err_nxt   = bus.imem_rsp_err;
                    state_nxt = OUT;
                end else if (wcnt == WAIT_LAST) begin
                    inst_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = OUT;
                end else begin
                    wcnt_nxt = wcnt + 8'd1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    cnt_nxt   = cnt + 32'd1;
                    state_nxt = NPC;
                end
            end
            NPC: begin
                if (bus.npc_valid) begin
                    pc_nxt    = bus.npc;
                    state_nxt = CHK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake valids come straight from state so no input can reach them.
    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_addr      = pc;
    assign bus.out_valid      = (state == OUT);
    assign bus.out_pc         = pc;
    assign bus.out_inst       = inst;
    assign bus.fetch_err      = err;
    assign bus.fetch_cnt      = cnt;

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Scoreboard bench for the fetch unit: a driver issues next-PCs and memory
// behaviour, a responder plays instruction memory, a monitor checks outputs.
module tb_ysyx_23060201_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060201_ifu_if bus ();

    ysyx_23060201_ifu #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          dly;
        logic        err;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];
    int   n_chk = 0, n_fail = 0;
    int   hs_count = 0, n_issued = 0;
    int   cyc = 0;
    int   req_lo = 0, req_hi = 0, out_lo = 0, out_hi = 0;
    bit   rdy_force = 1'b1;
    logic rst_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        rst_q = 1'b1;
        forever begin
            @(posedge clk);
            rst_q = rst;
        end
    end

    // Ready generator: random unless forced, with directed stall windows.
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc >= req_lo && cyc < req_hi) bus.imem_req_ready = 1'b0;
            else bus.imem_req_ready = rdy_force ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (cyc >= out_lo && cyc < out_hi) bus.out_ready = 1'b0;
            else bus.out_ready = rdy_force ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Memory: response valid in the dly-th cycle after acceptance; garbage otherwise.
    initial begin
        int   cnt;
        bit   acc;
        logic rst_s;
        mem_t cur;
        cnt = 0;
        cur = '{addr: 0, data: 0, dly: 0, err: 0};
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            acc = bus.imem_req_valid && bus.imem_req_ready && !rst;
            @(posedge clk);
            rst_s = rst;
            #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
            bus.imem_rsp_err   = 1'($urandom_range(0, 1));
            if (rst_s) cnt = 0;
            else begin
                if (acc && mem_q.size() > 0) begin
                    cur = mem_q.pop_front();
                    cnt = cur.dly;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = cur.data;
                        bus.imem_rsp_err   = cur.err;
                    end
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
                chk("rst_out_pc", bus.out_pc, RESET_PC);
                chk("rst_out_inst", bus.out_inst, 0);
                chk("rst_fetch_err", 32'(bus.fetch_err), 0);
                chk("rst_fetch_cnt", bus.fetch_cnt, 0);
                exp_q.delete();
                mem_q.delete();
                hs_count = 0;
            end else begin
                chk("fetch_cnt", bus.fetch_cnt, hs_count);
                if (bus.imem_req_valid) begin
                    chk("req_expected", 32'(mem_q.size()), 1);
                    if (mem_q.size() > 0) chk("imem_addr", bus.imem_addr, mem_q[0].addr);
                end
                if (bus.out_valid) begin
                    chk("out_expected", 32'(exp_q.size()), 1);
                    if (exp_q.size() > 0) begin
                        chk("out_pc", bus.out_pc, exp_q[0].pc);
                        chk("out_inst", bus.out_inst, exp_q[0].inst);
                        chk("fetch_err", 32'(bus.fetch_err), 32'(exp_q[0].err));
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            hs_count++;
                        end
                    end
                end
            end
        end
    end

    // Reference model: outcome of one fetch from pc alignment and memory behaviour.
    task automatic expect_fetch(input logic [31:0] pc, input int dly, input logic err,
                                input logic [31:0] data);
        exp_t e;
        mem_t m;
        e.pc = pc;
        if (pc[1:0] != 2'b00 || dly > TIMEOUT || err) begin
            e.inst = '0;
            e.err  = 1'b1;
        end else begin
            e.inst = data;
            e.err  = 1'b0;
        end
        if (pc[1:0] == 2'b00) begin
            m.addr = pc; m.data = data; m.dly = dly; m.err = err;
            mem_q.push_back(m);
        end
        exp_q.push_back(e);
        n_issued++;
    endtask

    // Return at posedge+1 of a cycle where the DUT sits waiting for npc.
    task automatic wait_npc();
        int g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
            if (hs_count != n_issued) begin
                bus.npc_valid = ($urandom_range(0, 3) == 0);
                bus.npc       = $urandom;
            end else bus.npc_valid = 1'b0;
        end while (hs_count != n_issued && g < 500);
        bus.npc_valid = 1'b0;
        chk("npc_state_reached", hs_count, n_issued);
    endtask

    task automatic measure(input bit first, input logic [31:0] pc, input int dly,
                           input logic err, input logic [31:0] data,
                           output int lat, output int req_lat);
        lat = 0;
        req_lat = 0;
        if (!first) begin
            expect_fetch(pc, dly, err, data);
            bus.npc       = pc;
            bus.npc_valid = 1'b1;
        end
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (req_lat == 0 && bus.imem_req_valid) req_lat = lat;
            if (bus.out_valid) break;
            if (lat == 1) begin
                @(posedge clk);
                #1;
                if (first) expect_fetch(pc, dly, err, data);
                else bus.npc_valid = 1'b0;
            end
        end
        chk("out_valid_seen", 32'(bus.out_valid), 1);
    endtask

    task automatic reset_fetch(output int lat, output int req_lat);
        n_issued = 0;
        rst = 1'b0;
        measure(1'b1, RESET_PC, 1, 1'b0, 32'h0000_0413, lat, req_lat);
    endtask

    task automatic rand_fetch();
        logic [31:0] pc;
        int lat, rl;
        pc = RESET_PC + 32'($urandom_range(0, 1023)) * 4;
        if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
        wait_npc();
        measure(1'b0, pc, $urandom_range(1, TIMEOUT + 2), 1'($urandom_range(0, 7) == 0),
                $urandom, lat, rl);
    endtask

    initial begin
        int lat, rl;
        rst = 1'b1;
        bus.npc_valid = 1'b0;
        bus.npc = '0;
        repeat (3) @(posedge clk);
        #1;

        reset_fetch(lat, rl);
        chk("first_out_lat", lat, 5);
        chk("first_req_lat", rl, 3);

        wait_npc();
        repeat (3) begin @(posedge clk); #1; end
        measure(1'b0, 32'h8000_0010, 1, 1'b0, $urandom, lat, rl);
        chk("redirect_lat", lat, 5);

        wait_npc();
        req_lo = cyc + 2; req_hi = cyc + 7;
        measure(1'b0, 32'h8000_0014, 1, 1'b0, $urandom, lat, rl);
        chk("req_stall_lat", lat, 10);

        wait_npc();
        out_lo = cyc + 4; out_hi = cyc + 8;
        measure(1'b0, 32'h8000_0018, 1, 1'b0, $urandom, lat, rl);
        chk("out_stall_lat", lat, 5);

        wait_npc();
        measure(1'b0, 32'h8000_0002, 1, 1'b0, $urandom, lat, rl);
        chk("misalign_lat", lat, 3);
        chk("misalign_no_req", rl, 0);

        wait_npc();
        measure(1'b0, 32'h8000_001c, 2, 1'b1, $urandom, lat, rl);
        chk("bus_err_lat", lat, 6);

        // Hold out_ready low so the late response lands while in OUT.
        wait_npc();
        out_lo = cyc + 6; out_hi = cyc + 10;
        measure(1'b0, 32'h8000_0020, TIMEOUT + 2, 1'b0, $urandom, lat, rl);
        chk("timeout_lat", lat, 8);

        rdy_force = 1'b0;
        repeat (40) rand_fetch();

        // Reset while the fetch is in WAIT.
        wait_npc();
        rdy_force = 1'b1;
        expect_fetch(32'h8000_0040, TIMEOUT + 2, 1'b0, $urandom);
        bus.npc = 32'h8000_0040;
        bus.npc_valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; bus.npc_valid = 1'b0; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        reset_fetch(lat, rl);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_req_lat", rl, 3);

        rdy_force = 1'b0;
        repeat (8) rand_fetch();
        wait_npc();
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
